// File: rtl/ifu_fetch_queue.sv
// -----------------------------------------------------------------------------
// ifu_fetch_queue
//   Fetch-side instruction queue in front of ifu_pipe. It owns the sequential
//   fetch PC, issues in-order word requests to instruction memory, reserves a
//   slot per request, fills slots from in-order responses and presents the
//   oldest filled slot downstream. A flush discards everything queued, counts
//   the responses still owed for discarded requests (drop_cnt) and restarts
//   fetch at flush_addr_i once those responses have drained.
//
// Optional feature macro: IFU_FETCH_QUEUE_BYPASS_EN
//   When defined, a response arriving for the head slot of a queue with no
//   filled slot is forwarded combinationally to the outputs (one cycle less
//   fetch latency). When undefined, outputs come only from registered slots.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   flush_flag_i         redirect request; flush_addr_i is the new fetch PC
//   stall_i              downstream hold (no pop while high)
//   req_valid_o/addr_o   fetch request to instruction memory
//   req_ready_i          memory accepts the request this cycle
//   rsp_valid_i/data_i   in-order response, always accepted
//   inst_valid_o         head slot holds an instruction
//   inst_o, inst_addr_o  head instruction/address (NOP / zero when invalid)
// -----------------------------------------------------------------------------

module ifu_fetch_queue_chk #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = 3
) (
    input logic          clk,
    input logic          rst_n,
    input logic          rsp_valid_i,
    input logic          drop_zero_i,
    input logic [CW-1:0] pending_i,
    input logic [CW-1:0] count_i
);
    // A response that is not being dropped must have a reserved, unfilled slot.
    assert property (@(posedge clk) disable iff (!rst_n)
        (rsp_valid_i && drop_zero_i) |-> (pending_i != {CW{1'b0}}));

    // Occupancy never exceeds the number of slots.
    assert property (@(posedge clk) disable iff (!rst_n)
        count_i <= CW'(DEPTH));
endmodule

module ifu_fetch_queue #(
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned INST_ADDR_WIDTH = 32,
    parameter int unsigned INST_DATA_WIDTH = 32,
    parameter logic [INST_ADDR_WIDTH-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [INST_DATA_WIDTH-1:0] INST_NOP = 32'h0000_0013
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush_flag_i,
    input  logic [INST_ADDR_WIDTH-1:0] flush_addr_i,
    input  logic                       stall_i,
    output logic                       req_valid_o,
    output logic [INST_ADDR_WIDTH-1:0] req_addr_o,
    input  logic                       req_ready_i,
    input  logic                       rsp_valid_i,
    input  logic [INST_DATA_WIDTH-1:0] rsp_data_i,
    output logic                       inst_valid_o,
    output logic [INST_DATA_WIDTH-1:0] inst_o,
    output logic [INST_ADDR_WIDTH-1:0] inst_addr_o
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [INST_ADDR_WIDTH-1:0] ZERO_WORD = {INST_ADDR_WIDTH{1'b0}};
    localparam logic [INST_ADDR_WIDTH-1:0] PC_STEP   = INST_ADDR_WIDTH'(4);

    logic [INST_ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [PW-1:0]              head_q, head_d;
    logic [PW-1:0]              fill_q, fill_d;
    logic [PW-1:0]              tail_q, tail_d;
    logic [CW-1:0]              count_q, count_d;   // allocated slots
    logic [CW-1:0]              filled_q, filled_d; // filled, not yet popped
    logic [CW-1:0]              drop_q, drop_d;     // responses owed to flushed requests
    logic [INST_ADDR_WIDTH-1:0] addr_q [DEPTH];
    logic [INST_DATA_WIDTH-1:0] data_q [DEPTH];

    logic          drop_zero_s;
    logic [CW-1:0] pending_s;
    logic          req_valid_s;
    logic          issue_s;
    logic          fill_s;
    logic          drop_s;
    logic          bypass_s;
    logic          inst_valid_s;
    logic          pop_s;

    // Handshake qualifiers: issue, fill, drop, bypass and pop for this cycle.
    always_comb begin
        drop_zero_s = (drop_q == {CW{1'b0}});
        pending_s   = count_q - filled_q;
        // rst_n gate keeps the request low while reset is asserted.
        req_valid_s = rst_n && !flush_flag_i && (count_q < DEPTH_C) && drop_zero_s;
        issue_s     = req_valid_s && req_ready_i;
        fill_s      = rsp_valid_i && drop_zero_s;
        drop_s      = rsp_valid_i && !drop_zero_s;
`ifdef IFU_FETCH_QUEUE_BYPASS_EN
        // With nothing filled, fill pointer equals head, so the response is for the head slot.
        bypass_s    = fill_s && (filled_q == {CW{1'b0}});
`else
        bypass_s    = 1'b0;
`endif
        // Filled count distinguishes full-and-filled from empty when head == fill.
        inst_valid_s = (filled_q != {CW{1'b0}}) || bypass_s;
        pop_s        = inst_valid_s && !stall_i && !flush_flag_i;
    end

    // Output selection: bypassed response, registered head slot, or idle values.
    always_comb begin
        req_valid_o  = req_valid_s;
        req_addr_o   = pc_q;
        inst_valid_o = inst_valid_s;
        if (bypass_s) begin
            inst_o      = rsp_data_i;
            inst_addr_o = addr_q[head_q];
        end else if (filled_q != {CW{1'b0}}) begin
            inst_o      = data_q[head_q];
            inst_addr_o = addr_q[head_q];
        end else begin
            inst_o      = INST_NOP;
            inst_addr_o = ZERO_WORD;
        end
    end

    // Next-state for PC, pointers and counters; flush overrides everything.
    always_comb begin
        pc_d     = pc_q;
        head_d   = head_q;
        fill_d   = fill_q;
        tail_d   = tail_q;
        count_d  = count_q;
        filled_d = filled_q;
        drop_d   = drop_q;
        if (flush_flag_i) begin
            pc_d     = flush_addr_i;
            head_d   = {PW{1'b0}};
            fill_d   = {PW{1'b0}};
            tail_d   = {PW{1'b0}};
            count_d  = {CW{1'b0}};
            filled_d = {CW{1'b0}};
            // Every request still unanswered after this cycle must be dropped later.
            drop_d   = pending_s - CW'(fill_s) + drop_q - CW'(drop_s);
        end else begin
            if (issue_s) begin
                pc_d = pc_q + PC_STEP;
            end else begin
                pc_d = pc_q;
            end
            tail_d   = tail_q + PW'(issue_s);
            fill_d   = fill_q + PW'(fill_s);
            head_d   = head_q + PW'(pop_s);
            count_d  = count_q + CW'(issue_s) - CW'(pop_s);
            // A bypassed pop nets to zero here: filled +1 and -1 in the same cycle.
            filled_d = filled_q + CW'(fill_s) - CW'(pop_s);
            drop_d   = drop_q - CW'(drop_s);
        end
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= RESET_PC;
            head_q   <= {PW{1'b0}};
            fill_q   <= {PW{1'b0}};
            tail_q   <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
            filled_q <= {CW{1'b0}};
            drop_q   <= {CW{1'b0}};
        end else begin
            pc_q     <= pc_d;
            head_q   <= head_d;
            fill_q   <= fill_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            filled_q <= filled_d;
            drop_q   <= drop_d;
        end
    end

    // Slot storage: address captured at issue, data captured at fill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                addr_q[i] <= ZERO_WORD;
                data_q[i] <= INST_NOP;
            end
        end else begin
            if (issue_s) begin
                addr_q[tail_q] <= pc_q;
            end
            if (fill_s && !flush_flag_i) begin
                data_q[fill_q] <= rsp_data_i;
            end
        end
    end

    ifu_fetch_queue_chk #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_chk (
        .clk         (clk),
        .rst_n       (rst_n),
        .rsp_valid_i (rsp_valid_i),
        .drop_zero_i (drop_zero_s),
        .pending_i   (pending_s),
        .count_i     (count_q)
    );
endmodule

// File: tb/tb_ifu_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_ifu_fetch_queue
//   Directed table of per-cycle vectors (streaming, stall/full, flush with
//   in-flight drops, flush coincident with the last response, back-to-back
//   flushes), a hand sequence for the bypass/registered latency, and a random
//   handshake phase against a simple in-order memory model.
// -----------------------------------------------------------------------------
module tb_ifu_fetch_queue;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] KEY = 32'h5A5A_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [31:0] flush_addr;
    logic        stall;
    logic        req_valid_o;
    logic [31:0] req_addr_o;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ifu_fetch_queue dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush_flag_i (flush),
        .flush_addr_i (flush_addr),
        .stall_i      (stall),
        .req_valid_o  (req_valid_o),
        .req_addr_o   (req_addr_o),
        .req_ready_i  (req_ready),
        .rsp_valid_i  (rsp_valid),
        .rsp_data_i   (rsp_data),
        .inst_valid_o (inst_valid_o),
        .inst_o       (inst_o),
        .inst_addr_o  (inst_addr_o)
    );

    typedef struct {
        logic        fl;
        logic [31:0] fa;
        logic        st;
        logic        rd;
        logic        rv;
        logic [31:0] rdat;
        logic        ev;
        logic [31:0] ea;
        logic        eiv;
        logic [31:0] ei;
        logic [31:0] eia;
    } vec_t;

    vec_t tv[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic fl, input logic [31:0] fa, input logic st, input logic rd,
                       input logic rv, input logic [31:0] rdat, input logic ev, input logic [31:0] ea,
                       input logic eiv, input logic [31:0] ei, input logic [31:0] eia);
        vec_t v;
        v.fl = fl; v.fa = fa; v.st = st; v.rd = rd; v.rv = rv; v.rdat = rdat;
        v.ev = ev; v.ea = ea; v.eiv = eiv; v.ei = ei; v.eia = eia;
        tv.push_back(v);
    endtask

    function automatic logic [31:0] d(input int n);
        return 32'hA000_0000 + 32'(n);
    endfunction

    logic [31:0] memq[$];
    logic [31:0] exp_req;
    logic [31:0] exp_pop;
    int          issued;
    int          popped;
    logic        fire;
    logic        popn;

    task automatic rnd_cycle(input logic rdy, input logic stl, input logic rsp_try);
        flush     = 1'b0;
        req_ready = rdy;
        stall     = stl;
        rsp_valid = (memq.size() > 0) && rsp_try;
        rsp_data  = rsp_valid ? (memq[0] ^ KEY) : 32'h0;
        #1;
        fire = req_valid_o && req_ready;
        popn = inst_valid_o && !stall;
        if (popn) begin
            chk("rnd inst_addr", inst_addr_o, exp_pop);
            chk("rnd inst", inst_o, exp_pop ^ KEY);
            exp_pop = exp_pop + 32'd4;
            popped++;
        end
        if (rsp_valid) void'(memq.pop_front());
        if (fire) begin
            chk("rnd req_addr", req_addr_o, exp_req);
            memq.push_back(exp_req);
            exp_req = exp_req + 32'd4;
            issued++;
        end
        chk("rnd occupancy<=4", {31'd0, (issued - popped) <= 4}, 32'd1);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; flush_addr = 32'h0; stall = 1'b0;
        req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = 32'h0;

        // fl fa st rd rv rdat | ev ea eiv ei eia
        // streaming, 1-cycle response latency
        add(0,0,0,1,0,0,          1,32'h00,0,NOP,0);
        add(0,0,0,1,1,d(0),       1,32'h04,0,NOP,0);
        add(0,0,0,1,1,d(1),       1,32'h08,1,d(0),32'h00);
        add(0,0,0,1,1,d(2),       1,32'h0C,1,d(1),32'h04);
        add(0,0,0,0,1,d(3),       1,32'h10,1,d(2),32'h08);
        add(0,0,0,0,0,0,          1,32'h10,1,d(3),32'h0C);
        // stall held: four issues then full
        add(0,0,1,1,0,0,          1,32'h10,0,NOP,0);
        add(0,0,1,1,1,d(4),       1,32'h14,0,NOP,0);
        add(0,0,1,1,1,d(5),       1,32'h18,1,d(4),32'h10);
        add(0,0,1,1,1,d(6),       1,32'h1C,1,d(4),32'h10);
        add(0,0,1,1,1,d(7),       0,32'h20,1,d(4),32'h10);
        add(0,0,1,1,0,0,          0,32'h20,1,d(4),32'h10);
        add(0,0,0,1,0,0,          0,32'h20,1,d(4),32'h10);
        add(0,0,0,1,0,0,          1,32'h20,1,d(5),32'h14);
        add(0,0,0,0,0,0,          1,32'h24,1,d(6),32'h18);
        add(0,0,0,0,1,d(8),       1,32'h24,1,d(7),32'h1C);
        add(0,0,0,0,0,0,          1,32'h24,1,d(8),32'h20);
        // two in flight, flush to 0x100, both responses dropped
        add(0,0,0,1,0,0,          1,32'h24,0,NOP,0);
        add(0,0,0,1,0,0,          1,32'h28,0,NOP,0);
        add(1,32'h100,0,1,0,0,    0,32'h2C,0,NOP,0);
        add(0,0,0,1,1,32'hDEAD0000, 0,32'h100,0,NOP,0);
        add(0,0,0,1,1,32'hDEAD0001, 0,32'h100,0,NOP,0);
        add(0,0,0,1,0,0,          1,32'h100,0,NOP,0);
        add(0,0,0,0,1,d(9),       1,32'h104,0,NOP,0);
        add(0,0,0,0,0,0,          1,32'h104,1,d(9),32'h100);
        // flush together with the last pending response: nothing to drop
        add(0,0,0,1,0,0,          1,32'h104,0,NOP,0);
        add(1,32'h200,0,0,1,32'hDEAD0002, 0,32'h108,0,NOP,0);
        add(0,0,0,1,0,0,          1,32'h200,0,NOP,0);
        // back-to-back flushes accumulate drop_cnt
        add(0,0,0,1,0,0,          1,32'h204,0,NOP,0);
        add(1,32'h300,0,1,1,32'hDEAD0003, 0,32'h208,0,NOP,0);
        add(1,32'h400,0,1,0,0,    0,32'h300,0,NOP,0);
        add(0,0,0,1,1,32'hDEAD0004, 0,32'h400,0,NOP,0);
        add(0,0,0,0,0,0,          1,32'h400,0,NOP,0);

        @(negedge clk);
        chk("reset req_valid", {31'd0, req_valid_o}, 32'd0);
        chk("reset req_addr", req_addr_o, 32'h0);
        chk("reset inst_valid", {31'd0, inst_valid_o}, 32'd0);
        chk("reset inst", inst_o, NOP);
        chk("reset inst_addr", inst_addr_o, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

`ifndef IFU_FETCH_QUEUE_BYPASS_EN
        for (int i = 0; i < tv.size(); i++) begin
            flush = tv[i].fl; flush_addr = tv[i].fa; stall = tv[i].st;
            req_ready = tv[i].rd; rsp_valid = tv[i].rv; rsp_data = tv[i].rdat;
            #1;
            chk($sformatf("v%0d req_valid", i), {31'd0, req_valid_o}, {31'd0, tv[i].ev});
            chk($sformatf("v%0d req_addr", i), req_addr_o, tv[i].ea);
            chk($sformatf("v%0d inst_valid", i), {31'd0, inst_valid_o}, {31'd0, tv[i].eiv});
            chk($sformatf("v%0d inst", i), inst_o, tv[i].ei);
            chk($sformatf("v%0d inst_addr", i), inst_addr_o, tv[i].eia);
            @(negedge clk);
        end
`endif

        // response latency into an empty queue at address 0x20
        flush = 1'b1; flush_addr = 32'h20; stall = 1'b0; req_ready = 1'b0;
        rsp_valid = 1'b0; rsp_data = 32'h0;
        @(negedge clk);
        flush = 1'b0; req_ready = 1'b1;
        #1;
        chk("lat req_valid", {31'd0, req_valid_o}, 32'd1);
        chk("lat req_addr", req_addr_o, 32'h20);
        @(negedge clk);
        req_ready = 1'b0; rsp_valid = 1'b1; rsp_data = 32'h0050_0093;
        #1;
`ifdef IFU_FETCH_QUEUE_BYPASS_EN
        chk("lat same-cycle valid", {31'd0, inst_valid_o}, 32'd1);
        chk("lat same-cycle inst", inst_o, 32'h0050_0093);
        chk("lat same-cycle addr", inst_addr_o, 32'h20);
`else
        chk("lat same-cycle valid", {31'd0, inst_valid_o}, 32'd0);
`endif
        @(negedge clk);
        rsp_valid = 1'b0; rsp_data = 32'h0;
        #1;
`ifdef IFU_FETCH_QUEUE_BYPASS_EN
        chk("lat next valid", {31'd0, inst_valid_o}, 32'd0);
`else
        chk("lat next valid", {31'd0, inst_valid_o}, 32'd1);
        chk("lat next inst", inst_o, 32'h0050_0093);
        chk("lat next addr", inst_addr_o, 32'h20);
`endif
        @(negedge clk);
        #1;
        chk("lat drained", {31'd0, inst_valid_o}, 32'd0);
        @(negedge clk);

        // random ready/response/stall against an in-order memory model
        exp_req = 32'h24; exp_pop = 32'h24; issued = 0; popped = 0;
        for (int c = 0; c < 400; c++) begin
            rnd_cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                      1'($urandom_range(0, 1)));
        end
        for (int c = 0; c < 100 && popped < issued; c++) begin
            rnd_cycle(1'b0, 1'b0, 1'b1);
        end
        chk("rnd all popped", 32'(popped), 32'(issued));
        chk("rnd final empty", {31'd0, inst_valid_o}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
